// File: rtl/rng_readout.sv
`default_nettype none
// ============================================================================
//  Module   : rng_readout
//  Brief    : Captures RNG words on in_valid rising edges into a small FIFO
//             and shows the head word one SEG_W-bit segment at a time.
//  Revision : 1.0
// ============================================================================
module rng_readout #(
    parameter  int DATA_W = 512,
    parameter  int SEG_W  = 8,
    parameter  int DEPTH  = 4,
    localparam int NSEG   = DATA_W / SEG_W,
    localparam int IW     = (NSEG > 1) ? $clog2(NSEG) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              next_seg,
    input  logic              clear_ovf,
    output logic [SEG_W-1:0]  out_seg,
    output logic [IW-1:0]     seg_idx,
    output logic              word_avail,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              overflow
);

    localparam int              PW          = $clog2(DEPTH);
    localparam logic [0:0]      c_st_empty  = 1'b0;
    localparam logic [0:0]      c_st_show   = 1'b1;
    localparam logic [CW-1:0]   c_depth     = CW'(DEPTH);
    localparam logic [CW-1:0]   c_one       = CW'(1);
    localparam logic [IW-1:0]   c_last_seg  = IW'(NSEG - 1);

    generate
        if ((DATA_W % SEG_W) != 0) begin : g_chk_seg
            $error("rng_readout: DATA_W must be an integer multiple of SEG_W");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
            $error("rng_readout: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_valid_q;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              r_full;
    logic              r_avail;
    logic              r_ovf;
    logic [IW-1:0]     r_seg_idx;
    logic [SEG_W-1:0]  r_out_seg;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_capture;
    logic              w_show;
    logic              w_adv;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;
    logic [SEG_W-1:0]  w_segs [NSEG];

    // One capture per 0->1 of in_valid; the edge register starts at 0 so a
    // level already high at reset release still produces a capture.
    assign w_capture = in_valid & ~r_valid_q;
    assign w_head    = r_mem[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            assign w_segs[gi] = w_head[gi*SEG_W +: SEG_W];
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_push) w_state_nxt = c_st_show;
            c_st_show:  if (w_pop && !w_push && (r_count == c_one)) w_state_nxt = c_st_empty;
            default:    w_state_nxt = c_st_empty;
        endcase
    end

    // ---------------- FSM: output / control decode ----------------
    always_comb begin
        w_show = (r_state == c_st_show);
        w_adv  = w_show & next_seg;
        w_pop  = w_adv & (r_seg_idx == c_last_seg);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        w_push = w_capture & (~r_full | w_pop);
        w_drop = w_capture & r_full & ~w_pop;
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_avail   <= 1'b0;
            r_ovf     <= 1'b0;
            r_seg_idx <= '0;
            r_out_seg <= '0;
        end else begin
            r_valid_q <= in_valid;
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == c_depth);
            r_avail   <= (w_count_nxt != '0);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_pop) begin
                r_seg_idx <= '0;
            end else if (w_adv) begin
                r_seg_idx <= r_seg_idx + IW'(1);
            end
            // A drop in the same cycle as clear_ovf wins.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
            r_out_seg <= w_show ? w_segs[r_seg_idx] : '0;
        end
    end

    // Storage is deliberately left unreset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    assign out_seg    = r_out_seg;
    assign seg_idx    = r_seg_idx;
    assign word_avail = r_avail;
    assign count      = r_count;
    assign full       = r_full;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rng_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rng_readout
//  Brief    : Self-checking bench for rng_readout (DATA_W=32, SEG_W=8, DEPTH=2).
//  Revision : 1.0
// ============================================================================
module tb_rng_readout;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        next_seg;
    logic        clear_ovf;
    logic [7:0]  out_seg;
    logic [1:0]  seg_idx;
    logic        word_avail;
    logic [1:0]  count;
    logic        full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    rng_readout #(.DATA_W(32), .SEG_W(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .next_seg   (next_seg),
        .clear_ovf  (clear_ovf),
        .out_seg    (out_seg),
        .seg_idx    (seg_idx),
        .word_avail (word_avail),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        cap;
        bit [31:0] data;
        bit        nseg;
        bit        clr;
        int        ecnt;
        bit        efull;
        bit        eovf;
        int        eidx;
    } vec_t;

    vec_t        vt [20];
    logic [31:0] sb_q [$];
    int          m_idx;

    function automatic vec_t mk(bit cap, bit [31:0] data, bit nseg, bit clr,
                                int ecnt, bit efull, bit eovf, int eidx);
        vec_t v;
        v.cap = cap; v.data = data; v.nseg = nseg; v.clr = clr;
        v.ecnt = ecnt; v.efull = efull; v.eovf = eovf; v.eidx = eidx;
        return v;
    endfunction

    function automatic logic [7:0] seg_of(logic [31:0] w, int idx);
        logic [31:0] t;
        t = w >> (idx * 8);
        return t[7:0];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int ecnt, bit efull, bit eovf, int eidx, logic [7:0] eseg);
        chk({tag, " count"},      32'(count),      32'(ecnt));
        chk({tag, " full"},       32'(full),       32'(efull));
        chk({tag, " word_avail"}, 32'(word_avail), 32'(ecnt != 0));
        chk({tag, " overflow"},   32'(overflow),   32'(eovf));
        chk({tag, " seg_idx"},    32'(seg_idx),    32'(eidx));
        chk({tag, " out_seg"},    32'(out_seg),    32'(eseg));
    endtask

    task automatic pulse_next();
        @(negedge clk);
        next_seg = 1'b1;
        @(posedge clk); #1;
        next_seg = 1'b0;
    endtask

    initial begin
        int          pre;
        bit          pop;
        logic [7:0]  eseg;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; next_seg = 1'b0; clear_ovf = 1'b0;

        vt[0]  = mk(1, 32'hA1B2C3D4, 0, 0, 1, 0, 0, 0);
        vt[1]  = mk(0, 32'h0,        1, 0, 1, 0, 0, 1);
        vt[2]  = mk(0, 32'h0,        1, 0, 1, 0, 0, 2);
        vt[3]  = mk(0, 32'h0,        1, 0, 1, 0, 0, 3);
        vt[4]  = mk(0, 32'h0,        1, 0, 0, 0, 0, 0);
        vt[5]  = mk(1, 32'h11111111, 0, 0, 1, 0, 0, 0);
        vt[6]  = mk(1, 32'h22222222, 0, 0, 2, 1, 0, 0);
        vt[7]  = mk(1, 32'h33333333, 0, 0, 2, 1, 1, 0);
        vt[8]  = mk(0, 32'h0,        0, 1, 2, 1, 0, 0);
        vt[9]  = mk(0, 32'h0,        1, 0, 2, 1, 0, 1);
        vt[10] = mk(0, 32'h0,        1, 0, 2, 1, 0, 2);
        vt[11] = mk(0, 32'h0,        1, 0, 2, 1, 0, 3);
        vt[12] = mk(1, 32'h44444444, 1, 0, 2, 1, 0, 0);
        vt[13] = mk(0, 32'h0,        1, 0, 2, 1, 0, 1);
        vt[14] = mk(0, 32'h0,        1, 0, 2, 1, 0, 2);
        vt[15] = mk(0, 32'h0,        1, 0, 2, 1, 0, 3);
        vt[16] = mk(0, 32'h0,        1, 0, 1, 0, 0, 0);
        vt[17] = mk(1, 32'h89ABCDEF, 0, 0, 2, 1, 0, 0);
        vt[18] = mk(1, 32'h66666666, 0, 1, 2, 1, 1, 0);
        vt[19] = mk(0, 32'h0,        0, 1, 2, 1, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 8'h00);
        rst_n = 1'b1;

        m_idx = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid  = vt[i].cap;
            in_data   = vt[i].data;
            next_seg  = vt[i].nseg;
            clear_ovf = vt[i].clr;
            pre = sb_q.size();
            pop = vt[i].nseg && (pre > 0) && (m_idx == 3);
            if (vt[i].nseg && (pre > 0)) m_idx = pop ? 0 : m_idx + 1;
            if (pop) void'(sb_q.pop_front());
            if (vt[i].cap && ((pre < 2) || pop)) sb_q.push_back(vt[i].data);
            @(posedge clk); #1;
            in_valid = 1'b0; next_seg = 1'b0; clear_ovf = 1'b0;
            @(posedge clk);
            @(negedge clk);
            eseg = (sb_q.size() > 0) ? seg_of(sb_q[0], m_idx) : 8'h00;
            chk_all($sformatf("vec%0d", i), vt[i].ecnt, vt[i].efull, vt[i].eovf, vt[i].eidx, eseg);
        end

        // Advance to seg_idx 2 on a full FIFO, then reset asynchronously
        pulse_next();
        pulse_next();
        @(negedge clk);
        chk_all("pre_reset", 2, 1, 0, 2, 8'h44);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hCAFEF00D;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 8'h00);

        // Release with in_valid already high, held for 10 cycles: one capture
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_all("held_high", 1, 0, 0, 0, 8'h0D);
        pulse_next();
        pulse_next();
        pulse_next();
        @(posedge clk);
        @(negedge clk);
        chk_all("held_seg3", 1, 0, 0, 3, 8'hCA);
        pulse_next();
        @(posedge clk);
        @(negedge clk);
        chk_all("held_pop", 0, 0, 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rng_readout.md
RNG_READOUT -- requirements
Module: rng_readout

Interface
REQ-001 Parameter DATA_W, default 512: width of one captured RNG word.
REQ-002 Parameter SEG_W, default 8: width of one displayed segment; DATA_W SHALL be an integer multiple of SEG_W (elaboration error otherwise).
REQ-003 Parameter DEPTH, default 4: number of word slots in the capture FIFO; power of two, >= 2.
REQ-004 Derived NSEG = DATA_W/SEG_W; IW = max(1, clog2(NSEG)); CW = clog2(DEPTH+1).
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  level "RNG word valid" from the generator.
REQ-008 in_data  in  DATA_W  RNG word, sampled only on capture.
REQ-009 next_seg  in  1  single-cycle pulse: advance to the next segment.
REQ-010 clear_ovf  in  1  single-cycle pulse: clear the overflow flag.
REQ-011 out_seg  out  SEG_W  registered segment of the head word.
REQ-012 seg_idx  out  IW  index of the segment currently shown.
REQ-013 word_avail  out  1  high when the FIFO is non-empty.
REQ-014 count  out  CW  number of words held.
REQ-015 full  out  1  high when count == DEPTH.
REQ-016 overflow  out  1  sticky: a capture was dropped.

Function
REQ-017 Capture SHALL occur on the cycle following a 0->1 transition of registered in_valid; a held-high in_valid SHALL yield exactly one capture.
REQ-018 Capture SHALL push in_data (value present on the edge-detect cycle) into the FIFO tail.
REQ-019 The block SHALL have two states: EMPTY (count == 0) and SHOW (count > 0).
REQ-020 EMPTY -> SHOW on a capture; SHOW -> EMPTY when the last word is popped with no simultaneous capture.
REQ-021 In EMPTY: out_seg = 0, seg_idx = 0, next_seg ignored.
REQ-022 In SHOW: out_seg SHALL equal bits [seg_idx*SEG_W +: SEG_W] of the head word, updated one cycle after any seg_idx or head change.
REQ-023 next_seg in SHOW with seg_idx < NSEG-1 SHALL increment seg_idx.
REQ-024 next_seg in SHOW with seg_idx == NSEG-1 SHALL pop the head word and reset seg_idx to 0.
REQ-025 Capture while full with no pop in the same cycle SHALL discard the word, leave FIFO contents unchanged, and set overflow.
REQ-026 Capture and pop in the same cycle SHALL both take effect; count unchanged; no overflow even when full.
REQ-027 Capture into an empty FIFO SHALL make the new word the head, shown from seg_idx 0.
REQ-028 Pointers SHALL wrap modulo DEPTH without loss.
REQ-029 clear_ovf SHALL clear overflow; clear_ovf and a new drop in the same cycle SHALL leave overflow set.
REQ-030 word_avail, full, count SHALL be registered and consistent in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force: count = 0, pointers = 0, seg_idx = 0, out_seg = 0, word_avail = 0, full = 0, overflow = 0, in_valid edge register = 0, state EMPTY.
REQ-032 Reset mid-operation SHALL discard all stored words; FIFO storage contents need not be cleared.
REQ-033 After rst_n release, in_valid already high SHALL cause one capture (edge register starts at 0).

Verification (DATA_W=32, SEG_W=8, DEPTH=2)
REQ-034 in_valid rises with in_data=0xA1B2C3D4 -> word_avail=1, count=1, out_seg=0xD4, seg_idx=0; three next_seg pulses -> out_seg 0xC3, 0xB2, 0xA1.
REQ-035 Fourth next_seg -> pop: count=0, word_avail=0, out_seg=0x00, seg_idx=0.
REQ-036 Three captures (0x11111111, 0x22222222, 0x33333333), no next_seg -> count=2, full=1, overflow=1, head out_seg=0x11; after draining word 1, out_seg=0x22.
REQ-037 Full FIFO at seg_idx=3, next_seg coincident with capture edge of 0x44444444 -> count stays 2, overflow stays 0, out_seg=0x22 next.
REQ-038 in_valid held high for 10 cycles -> exactly one capture; clear_ovf after overflow -> overflow=0.
REQ-039 rst_n asserted with count=2, seg_idx=2 -> all outputs zero asynchronously, before the next clk edge.
